// File: rtl/mux_sel_sequencer_pkg.sv
// Shared state encoding and default geometry for the mux select sequencer.
package mux_sel_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 3;
  localparam int DEF_DIV   = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SETTLE = 2'd1,
    SEQ_SAMPLE = 2'd2,
    SEQ_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mux_sel_sequencer_settle_timer.sv
// Settle window timer: loads DIV-1 on start, counts down, and pulses expire
// in the last cycle of the window (so the window is exactly DIV cycles).
module settle_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expire
);

  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             running;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= LOAD_VAL;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Drives a WIDTH-to-1 mux with a held word, walks the select lines, samples
// the mux output after each settle window and streams the samples out.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] i_out,
  output logic [SEL_W-1:0] s_out,
  input  logic             y_in,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             frame_done,
  output logic             busy,
  output logic             err
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] i_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic             load_ready_nxt, bit_valid_nxt, bit_out_nxt;
  logic             frame_done_nxt, busy_nxt, err_nxt;
  logic             timer_start, timer_expire;

  settle_timer #(.DIV(DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEQ_IDLE;
      load_ready <= 1'b1;
      i_out      <= '0;
      s_out      <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_ready <= load_ready_nxt;
      i_out      <= i_nxt;
      s_out      <= s_nxt;
      bit_valid  <= bit_valid_nxt;
      bit_out    <= bit_out_nxt;
      frame_done <= frame_done_nxt;
      busy       <= busy_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_ready_nxt = load_ready;
    i_nxt          = i_out;
    s_nxt          = s_out;
    bit_valid_nxt  = 1'b0;
    bit_out_nxt    = bit_out;
    frame_done_nxt = 1'b0;
    busy_nxt       = busy;
    err_nxt        = err;
    timer_start    = 1'b0;

    case (state)
      SEQ_IDLE: begin
        load_ready_nxt = 1'b1;
        if (load_valid && load_ready) begin
          i_nxt          = load_data;
          s_nxt          = '0;
          err_nxt        = 1'b0;
          busy_nxt       = 1'b1;
          load_ready_nxt = 1'b0;
          timer_start    = 1'b1;
          state_nxt      = SEQ_SETTLE;
        end
      end
      SEQ_SETTLE: begin
        if (timer_expire) state_nxt = SEQ_SAMPLE;
      end
      SEQ_SAMPLE: begin
        bit_out_nxt   = y_in;
        bit_valid_nxt = 1'b1;
        if (y_in != i_out[s_out]) err_nxt = 1'b1;
        if (s_out == SEL_LAST) begin
          state_nxt = SEQ_DONE;
        end else begin
          s_nxt       = s_out + SEL_ONE;
          timer_start = 1'b1;
          state_nxt   = SEQ_SETTLE;
        end
      end
      SEQ_DONE: begin
        frame_done_nxt = 1'b1;
        busy_nxt       = 1'b0;
        load_ready_nxt = 1'b1;
        s_nxt          = '0;
        state_nxt      = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer driving an ideal 8-to-1 mux (DIV=4 and DIV=1 builds).
module tb_mux_sel_sequencer;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int L   = W * (DIV + 1) + 1;
  localparam int NF  = 10;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] i_out;
  logic [2:0] s_out;
  logic       y;
  logic       bit_valid, bit_out, frame_done, busy, err;
  bit         force0;

  logic       b_load_valid;
  logic [7:0] b_load_data;
  logic       b_load_ready;
  logic [7:0] b_i_out;
  logic [2:0] b_s_out;
  logic       b_y;
  logic       b_bit_valid, b_bit_out, b_frame_done, b_busy, b_err;

  int vectors;
  int miscompares;

  // Ideal mux, with an optional stuck-at-0 output for error injection.
  assign y   = force0 ? 1'b0 : i_out[s_out];
  assign b_y = b_i_out[b_s_out];

  mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .i_out(i_out), .s_out(s_out), .y_in(y),
    .bit_valid(bit_valid), .bit_out(bit_out), .frame_done(frame_done),
    .busy(busy), .err(err)
  );

  mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_data(b_load_data),
    .load_ready(b_load_ready), .i_out(b_i_out), .s_out(b_s_out), .y_in(b_y),
    .bit_valid(b_bit_valid), .bit_out(b_bit_out), .frame_done(b_frame_done),
    .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    bit         f0;
    bit         junk;
    bit         chain;
    logic [7:0] exp_bits;
    bit         exp_err;
  } frame_vec_t;

  frame_vec_t tbl [NF];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has already presented the word; the next edge is the accept edge.
  task automatic run_frame(input frame_vec_t v, input logic [7:0] nxt);
    bit err_e;
    int k;
    int s_e;
    chk("load_ready_pre", int'(load_ready), 1);
    force0 = v.f0;
    tick();
    load_valid = v.junk;
    load_data  = v.junk ? 8'hFF : 8'h00;
    err_e = 1'b0;
    for (int n = 1; n <= L; n++) begin
      tick();
      if ((n % (DIV + 1)) == 0 && n < L) begin
        k = n / (DIV + 1) - 1;
        if (v.exp_bits[k] != v.w[k]) err_e = 1'b1;
        chk("bit_valid", int'(bit_valid), 1);
        chk("bit_out", int'(bit_out), int'(v.exp_bits[k]));
      end else begin
        chk("bit_valid_idle", int'(bit_valid), 0);
      end
      s_e = (n == L) ? 0 : ((n / (DIV + 1)) > W - 1 ? W - 1 : n / (DIV + 1));
      chk("frame_done", int'(frame_done), int'(n == L));
      chk("busy", int'(busy), int'(n < L));
      chk("load_ready", int'(load_ready), int'(n == L));
      chk("i_out", int'(i_out), int'(v.w));
      chk("s_out", int'(s_out), s_e);
      chk("err", int'(err), int'(err_e));
    end
    chk("err_final", int'(err), int'(v.exp_err));
    if (v.chain) begin
      load_valid = 1'b1;
      load_data  = nxt;
    end else begin
      load_valid = 1'b0;
      tick();
      chk("err_sticky_idle", int'(err), int'(v.exp_err));
      chk("load_ready_idle", int'(load_ready), 1);
      chk("i_out_kept", int'(i_out), int'(v.w));
    end
  endtask

  initial begin
    bit         seen;
    logic [7:0] b_word;
    frame_vec_t rv;

    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    b_load_valid = 1'b0;
    b_load_data  = 8'h00;
    force0       = 1'b0;

    tick();
    tick();
    chk("rst_load_ready", int'(load_ready), 1);
    chk("rst_i_out", int'(i_out), 0);
    chk("rst_s_out", int'(s_out), 0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_bit_out", int'(bit_out), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_b_load_ready", int'(b_load_ready), 1);
    rst = 1'b0;
    tick();

    // Fixed vectors: junk during frame, chained load, stuck-at-0 mux, error clear.
    tbl[0] = '{w: 8'b01100110, f0: 1'b0, junk: 1'b1, chain: 1'b1, exp_bits: 8'b01100110, exp_err: 1'b0};
    tbl[1] = '{w: 8'h3C,       f0: 1'b0, junk: 1'b0, chain: 1'b0, exp_bits: 8'b00111100, exp_err: 1'b0};
    tbl[2] = '{w: 8'hFF,       f0: 1'b1, junk: 1'b0, chain: 1'b0, exp_bits: 8'h00,       exp_err: 1'b1};
    tbl[3] = '{w: 8'h5A,       f0: 1'b0, junk: 1'b0, chain: 1'b0, exp_bits: 8'h5A,       exp_err: 1'b0};
    for (int i = 4; i < NF; i++) begin
      rv.w        = 8'($urandom);
      rv.f0       = 1'($urandom_range(0, 1));
      rv.junk     = 1'($urandom_range(0, 1));
      rv.chain    = (i < NF - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rv.exp_bits = rv.f0 ? 8'h00 : rv.w;
      rv.exp_err  = rv.f0 && (rv.w != 8'h00);
      tbl[i] = rv;
    end

    for (int i = 0; i < NF; i++) begin
      if (i == 0 || !tbl[i-1].chain) begin
        load_valid = 1'b1;
        load_data  = tbl[i].w;
      end
      run_frame(tbl[i], (i < NF - 1) ? tbl[i+1].w : 8'h00);
    end

    // Reset in the middle of a frame.
    force0     = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hC3;
    tick();
    load_valid = 1'b0;
    for (int n = 1; n <= 16; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_s_out", int'(s_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_load_ready", int'(load_ready), 1);
    chk("midrst_i_out", int'(i_out), 0);
    chk("midrst_bit_valid", int'(bit_valid), 0);
    seen = 1'b0;
    for (int n = 0; n < 45; n++) begin
      tick();
      if (bit_valid || frame_done) seen = 1'b1;
    end
    chk("midrst_no_stray_pulse", int'(seen), 0);
    load_valid = 1'b1;
    load_data  = 8'h81;
    rv = '{w: 8'h81, f0: 1'b0, junk: 1'b0, chain: 1'b0, exp_bits: 8'h81, exp_err: 1'b0};
    run_frame(rv, 8'h00);

    // DIV=1 build: one settle cycle, a bit every 2 cycles.
    b_word       = 8'hA5;
    b_load_valid = 1'b1;
    b_load_data  = b_word;
    tick();
    b_load_valid = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if ((n % 2) == 0 && n < 17) begin
        chk("b_bit_valid", int'(b_bit_valid), 1);
        chk("b_bit_out", int'(b_bit_out), int'(b_word[n/2-1]));
      end else begin
        chk("b_bit_valid_idle", int'(b_bit_valid), 0);
      end
      chk("b_frame_done", int'(b_frame_done), int'(n == 17));
    end
    chk("b_err", int'(b_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
